// File: rtl/ex_mul_seq.sv
// Iterative shift-add multiplier for the EX stage.
// Each BUSY cycle folds STEPS multiplier bits into a 64-bit accumulator through
// a chain of adder_64_bit instances. After 64/STEPS cycles the requested product
// word is presented on the response port until it is consumed or flushed.

module adder_64_bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        c_in,
  output logic [63:0] sum
);

  // Plain modulo-2^64 addition; any carry out of bit 63 is discarded.
  assign sum = a + b + {63'd0, c_in};

endmodule

module ex_mul_seq #(
  parameter int STEPS = 4,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [1:0]       req_func,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag
);

  localparam int N     = 64 / STEPS;
  localparam int CNT_W = $clog2(N);

  localparam logic [1:0] FUNC_MUL    = 2'b00;
  localparam logic [1:0] FUNC_MULH   = 2'b01;
  localparam logic [1:0] FUNC_MULHSU = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [63:0]      acc;
  logic [63:0]      mcand;
  logic [63:0]      mplier;
  logic [CNT_W-1:0] counter;
  logic [1:0]       func_q;

  logic             a_signed;
  logic             b_signed;
  logic [63:0]      a_ext;
  logic [63:0]      b_ext;
  logic [63:0]      acc_chain [0:STEPS];
  logic [63:0]      acc_next;

  // A new request is only taken when idle and not being killed or reset.
  assign req_ready = (state == IDLE) & ~flush & ~reset;

  // rs1 is signed for MULH/MULHSU, rs2 only for MULH; MUL and MULHU zero-extend.
  assign a_signed = (req_func == FUNC_MULH) | (req_func == FUNC_MULHSU);
  assign b_signed = (req_func == FUNC_MULH);
  assign a_ext    = {{32{a_signed & req_a[31]}}, req_a};
  assign b_ext    = {{32{b_signed & req_b[31]}}, req_b};

  assign acc_chain[0] = acc;

  // One adder per multiplier bit consumed this cycle, chained low bit first.
  for (genvar k = 0; k < STEPS; k++) begin : g_step
    logic [63:0] addend;
    assign addend = mplier[k] ? (mcand << k) : 64'd0;
    adder_64_bit u_add (
      .a    (acc_chain[k]),
      .b    (addend),
      .c_in (1'b0),
      .sum  (acc_chain[k+1])
    );
  end

  assign acc_next = acc_chain[STEPS];

  // Sequencer: accept, iterate for a fixed N cycles, then hold the result until consumed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= 64'd0;
      mcand      <= 64'd0;
      mplier     <= 64'd0;
      counter    <= '0;
      func_q     <= 2'b00;
      resp_valid <= 1'b0;
      resp_data  <= 32'd0;
      resp_tag   <= '0;
    end else if (flush) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid & req_ready) begin
            mcand    <= a_ext;
            mplier   <= b_ext;
            func_q   <= req_func;
            resp_tag <= req_tag;
            acc      <= 64'd0;
            counter  <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc     <= acc_next;
          mcand   <= mcand << STEPS;
          mplier  <= mplier >> STEPS;
          counter <= counter + CNT_W'(1);
          if (counter == CNT_LAST) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_data  <= (func_q == FUNC_MUL) ? acc_next[31:0] : acc_next[63:32];
          end
        end
        DONE: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mul_seq.sv
// Self-checking bench for ex_mul_seq (STEPS=4, TAG_W=5).
// A transaction-level model predicts ready/valid/data/tag from plain 64-bit
// arithmetic and a fixed latency; directed tests add literal expectations.

module tb_ex_mul_seq;

  localparam int STEPS = 4;
  localparam int TAG_W = 5;
  localparam int N     = 64 / STEPS;

  localparam logic [1:0] F_MUL    = 2'b00;
  localparam logic [1:0] F_MULH   = 2'b01;
  localparam logic [1:0] F_MULHSU = 2'b10;
  localparam logic [1:0] F_MULHU  = 2'b11;

  logic             clock;
  logic             reset;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [1:0]       req_func;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;

  int n_checks = 0;
  int n_fail   = 0;

  ex_mul_seq #(.STEPS(STEPS), .TAG_W(TAG_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_func   (req_func),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag)
  );

  // 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference product word computed with ordinary signed/unsigned 64-bit multiplies.
  function automatic logic [31:0] refMul(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] func);
    int     sa;
    int     sb;
    longint la;
    longint lb;
    longint p;
    sa = a;
    sb = b;
    case (func)
      F_MULH:   begin la = sa; lb = sb; end
      F_MULHSU: begin la = sa; lb = longint'({32'd0, b}); end
      default:  begin la = longint'({32'd0, a}); lb = longint'({32'd0, b}); end
    endcase
    p = la * lb;
    return (func == F_MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction model: one op in flight, result visible N edges after accept.
  bit               m_pending;
  int               m_cycle;
  int               m_due;
  logic [31:0]      m_data;
  logic [TAG_W-1:0] m_tag;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pending <= 1'b0;
    end else begin
      m_cycle <= m_cycle + 1;
      if (flush) begin
        m_pending <= 1'b0;
      end else if (!m_pending && req_valid) begin
        m_pending <= 1'b1;
        m_due     <= m_cycle + 1 + N;
        m_data    <= refMul(req_a, req_b, req_func);
        m_tag     <= req_tag;
      end else if (m_pending && (m_cycle >= m_due) && resp_ready) begin
        m_pending <= 1'b0;
      end
    end
  end

  // Compare every cycle, away from the rising edge.
  always @(negedge clock) begin
    bit exp_valid;
    bit exp_ready;
    exp_valid = m_pending && (m_cycle >= m_due) && !reset;
    exp_ready = !m_pending && !flush && !reset;
    checkOutput("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
    checkOutput("resp_valid", {31'd0, resp_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      checkOutput("resp_data", resp_data, m_data);
      checkOutput("resp_tag", {27'd0, resp_tag}, {27'd0, m_tag});
    end
    if (reset) begin
      checkOutput("reset_data", resp_data, 32'd0);
      checkOutput("reset_tag", {27'd0, resp_tag}, 32'd0);
    end
  end

  // Present a request and hold it until accepted; operands are scrambled afterwards.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] func, input logic [TAG_W-1:0] tag);
    bit rdy;
    @(posedge clock);
    #1;
    req_a     = a;
    req_b     = b;
    req_func  = func;
    req_tag   = tag;
    req_valid = 1'b1;
    rdy       = 1'b0;
    for (int i = 0; i < 200 && !rdy; i++) begin
      @(negedge clock);
      rdy = req_ready;
      @(posedge clock);
    end
    if (!rdy) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: request never accepted");
    end
    #1;
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    req_func  = 2'($urandom_range(0, 3));
    req_tag   = TAG_W'($urandom_range(0, 31));
  endtask

  // Wait for the response right after an accept and pin latency, data and tag.
  task automatic waitResp(input string name, input logic [31:0] exp_data,
                          input logic [TAG_W-1:0] exp_tag);
    int lat;
    lat = -1;
    for (int i = 0; i < 200 && lat < 0; i++) begin
      @(negedge clock);
      if (resp_valid) lat = i;
    end
    checkOutput({name, "_latency"}, lat, N);
    checkOutput({name, "_data"}, resp_data, exp_data);
    checkOutput({name, "_tag"}, {27'd0, resp_tag}, {27'd0, exp_tag});
  endtask

  initial begin
    int seen;
    reset      = 1'b1;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_a      = 32'd0;
    req_b      = 32'd0;
    req_func   = 2'b00;
    req_tag    = '0;
    resp_ready = 1'b1;
    m_cycle    = 0;
    m_due      = 0;
    m_data     = 32'd0;
    m_tag      = '0;

    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("rst_valid", {31'd0, resp_valid}, 32'd0);
    #2;
    reset = 1'b0;

    // Basic MUL and ready returning the cycle after the handshake.
    applyStimulus(32'd7, 32'd6, F_MUL, 5'd3);
    waitResp("mul_7x6", 32'h0000002A, 5'd3);
    @(negedge clock);
    checkOutput("ready_after_hs", {31'd0, req_ready}, 32'd1);

    // All-ones operands across the four functions.
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, F_MULH, 5'd1);
    waitResp("mulh_ff", 32'h00000000, 5'd1);
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, F_MULHU, 5'd2);
    waitResp("mulhu_ff", 32'hFFFFFFFE, 5'd2);
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, F_MULHSU, 5'd4);
    waitResp("mulhsu_ff", 32'hFFFFFFFF, 5'd4);
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, F_MUL, 5'd5);
    waitResp("mul_ff", 32'h00000001, 5'd5);

    // Most-negative operands.
    applyStimulus(32'h80000000, 32'h80000000, F_MULH, 5'd6);
    waitResp("mulh_80", 32'h40000000, 5'd6);
    applyStimulus(32'h80000000, 32'h80000000, F_MUL, 5'd7);
    waitResp("mul_80", 32'h00000000, 5'd7);
    applyStimulus(32'h80000000, 32'h80000000, F_MULHU, 5'd8);
    waitResp("mulhu_80", 32'h40000000, 5'd8);

    // Backpressure: result held, new request ignored until after the handshake.
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    applyStimulus(32'd100, 32'd200, F_MUL, 5'd10);
    waitResp("bp_first", 32'd20000, 5'd10);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      req_valid = (i % 2) == 0;
      req_a     = 32'd11;
      req_b     = 32'd13;
      req_func  = F_MUL;
      req_tag   = 5'd11;
      @(negedge clock);
      checkOutput("bp_ready", {31'd0, req_ready}, 32'd0);
      checkOutput("bp_valid", {31'd0, resp_valid}, 32'd1);
      checkOutput("bp_data", resp_data, 32'd20000);
      checkOutput("bp_tag", {27'd0, resp_tag}, 32'd10);
    end
    @(posedge clock);
    #1;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    applyStimulus(32'd11, 32'd13, F_MUL, 5'd11);
    waitResp("bp_second", 32'd143, 5'd11);

    // Flush mid-BUSY kills the op; the next op is unaffected.
    applyStimulus(32'd1234, 32'd5678, F_MUL, 5'd12);
    repeat (7) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    @(negedge clock);
    checkOutput("flush_ready", {31'd0, req_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (resp_valid) seen++;
    end
    checkOutput("flush_no_resp", seen, 32'd0);
    applyStimulus(32'd3, 32'd5, F_MUL, 5'd9);
    waitResp("after_flush", 32'd15, 5'd9);

    // Asynchronous reset in the middle of BUSY.
    applyStimulus(32'd77, 32'd99, F_MULHU, 5'd20);
    repeat (5) @(posedge clock);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("arst_data", resp_data, 32'd0);
    checkOutput("arst_tag", {27'd0, resp_tag}, 32'd0);
    checkOutput("arst_ready", {31'd0, req_ready}, 32'd0);
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post_rst_ready", {31'd0, req_ready}, 32'd1);
    applyStimulus(32'h00010000, 32'h00010000, F_MULHU, 5'd21);
    waitResp("post_rst_mulhu", 32'h00000001, 5'd21);

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
